// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared constants, owner encoding and rotating-priority search
// Owner encoding is one-hot: bit IDLE_IDX is IDLE, bit p+1 is SERVE(p).
package noc_arb_pkg;

  localparam int MAX_PORTS = 16;
  localparam int IDLE_IDX  = 0;

  function automatic int owner_w(input int n);
    return n + 1;
  endfunction

  typedef logic [owner_w(MAX_PORTS)-1:0] owner_max_t;

  // First requesting index at or after the start port, wrapping at n; an all-zero start scans from 0.
  function automatic logic [MAX_PORTS-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_PORTS-1:0] start,
    input logic                 exclude_start,
    input int                   n
  );
    logic [MAX_PORTS-1:0] cand;
    logic [MAX_PORTS-1:0] win;
    logic                 found;
    int                   s;
    int                   idx;
    cand  = exclude_start ? (req & ~start) : req;
    s     = 0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (start[i]) s = i;
    end
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < n) begin
        idx = s + k;
        if (idx >= n) idx = idx - n;
        if (!found && cand[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - combinational rotating-priority search returning a one-hot winner
module noc_rr_pick #(
  parameter int N = 5
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] start_i,
  input  logic [N-1:0] mask_i,
  output logic [N-1:0] winner_o,
  output logic         valid_o
);
  import noc_arb_pkg::*;

  logic [MAX_PORTS-1:0] win_full;
  logic                 unused_win_hi;

  assign win_full      = rr_pick(MAX_PORTS'(req_i & mask_i), MAX_PORTS'(start_i),
                                 |(start_i & ~mask_i), N);
  assign winner_o      = win_full[N-1:0];
  assign valid_o       = |winner_o;
  assign unused_win_hi = ^win_full;

endmodule

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - sticky round-robin output-link arbiter with RTS/DCTS handshake
// Define ARB_GRANT_CNT_EN to add saturating per-port grant counters on grant_cnt.
module noc_rr_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] grant_cnt
`endif
);
  import noc_arb_pkg::*;

  localparam int OW = owner_w(NUM_PORTS);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef logic [OW-1:0] owner_t;

  localparam owner_t         OWNER_IDLE = owner_t'(1) << IDLE_IDX;
  localparam logic [HW-1:0]  HOLD_MAX   = HW'(MAX_HOLD);

  owner_t                owner_q, owner_d;
  logic                  rts_q, rts_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [NUM_PORTS-1:0]  serve, mask, winner;
  logic                  valid, stall, xfer, hold_lim;

  assign serve    = owner_q[NUM_PORTS:1];
  assign stall    = rts_q & ~dcts;
  assign xfer     = |grant;
  assign hold_lim = (MAX_HOLD > 0) && (hold_q == HOLD_MAX) && |(req & ~serve);
  assign mask     = hold_lim ? ~serve : '1;

  noc_rr_pick #(.N(NUM_PORTS)) u_pick (
    .req_i   (req),
    .start_i (serve),
    .mask_i  (mask),
    .winner_o(winner),
    .valid_o (valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWNER_IDLE;
      rts_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      rts_q   <= rts_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    if (!stall) owner_d = valid ? {winner, 1'b0} : OWNER_IDLE;
  end

  // RTS drops for one cycle after every completed handshake.
  always_comb begin
    rts_d = 1'b1;
    if (owner_q[IDLE_IDX])  rts_d = 1'b0;
    else if (rts_q && dcts) rts_d = 1'b0;
  end

  always_comb begin
    hold_d = hold_q;
    if (!stall) begin
      if (owner_d != owner_q)            hold_d = '0;
      else if (xfer && hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
    end
  end

  // A transfer in the reset cycle is aborted, so grant is masked by rst.
  always_comb begin
    xbar_sel = serve;
    grant    = (rts_q && dcts && !rst) ? serve : '0;
    rts      = rts_q;
  end

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] cnt_d [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (grant[p] && cnt_q[p] != '1) cnt_d[p] = cnt_q[p] + CNT_W'(1);
      grant_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst) cnt_q[p] <= '0;
      else     cnt_q[p] <= cnt_d[p];
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb/tb_noc_rr_arbiter.sv - bench for noc_rr_arbiter: directed scenarios plus randomized model comparison
module tb_noc_rr_arbiter;
  localparam int NP = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NP-1:0] req_v  [2];
  logic          dcts_v [2];
  logic [NP-1:0] grant_v[2];
  logic [NP-1:0] xbar_v [2];
  logic          rts_v  [2];
`ifdef ARB_GRANT_CNT_EN
  logic [NP*8-1:0] cnt_a;
  logic [NP*2-1:0] cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;
  int maxh[2] = '{0, 2};
  int cmax[2] = '{255, 3};

  int   m_owner[2] = '{-1, -1};
  logic m_rts  [2] = '{1'b0, 1'b0};
  int   m_hold [2] = '{0, 0};
  int   m_cnt  [2][NP];

  noc_rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_v[0]), .dcts(dcts_v[0]),
    .grant(grant_v[0]), .xbar_sel(xbar_v[0]), .rts(rts_v[0])
`ifdef ARB_GRANT_CNT_EN
    , .grant_cnt(cnt_a)
`endif
  );

  noc_rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_v[1]), .dcts(dcts_v[1]),
    .grant(grant_v[1]), .xbar_sel(xbar_v[1]), .rts(rts_v[1])
`ifdef ARB_GRANT_CNT_EN
    , .grant_cnt(cnt_b)
`endif
  );

  // Reference model: owner is a port number (-1 = idle), search by modular walk.
  function automatic int nxt_owner(int own, int hold, logic [NP-1:0] r, int mh);
    logic [NP-1:0] others;
    logic          skip;
    int            p;
    if (own < 0) begin
      for (int q = 0; q < NP; q++) if (r[q]) return q;
      return -1;
    end
    others      = r;
    others[own] = 1'b0;
    skip        = (mh > 0) && (hold >= mh) && (others != 0);
    for (int k = 0; k < NP; k++) begin
      p = (own + k) % NP;
      if (!(skip && p == own) && r[p]) return p;
    end
    return -1;
  endfunction

  function automatic int nxt_hold(int own, int hold, logic [NP-1:0] r, int mh, logic g);
    if (nxt_owner(own, hold, r, mh) != own) return 0;
    if (g) return (hold + 1 > mh) ? mh : hold + 1;
    return hold;
  endfunction

  function automatic logic [NP-1:0] exp_xbar(int i);
    return (m_owner[i] >= 0) ? (NP'(1) << m_owner[i]) : '0;
  endfunction

  function automatic logic [NP-1:0] exp_grant(int i);
    return (!rst && m_rts[i] && dcts_v[i]) ? exp_xbar(i) : '0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_owner[i] <= -1;
        m_rts[i]   <= 1'b0;
        m_hold[i]  <= 0;
        for (int p = 0; p < NP; p++) m_cnt[i][p] <= 0;
      end else begin
        m_rts[i] <= (m_owner[i] >= 0) && !(m_rts[i] && dcts_v[i]);
        if (!(m_rts[i] && !dcts_v[i])) begin
          m_owner[i] <= nxt_owner(m_owner[i], m_hold[i], req_v[i], maxh[i]);
          m_hold[i]  <= nxt_hold(m_owner[i], m_hold[i], req_v[i], maxh[i], exp_grant(i) != 0);
        end
        for (int p = 0; p < NP; p++)
          if (exp_grant(i) != 0 && m_owner[i] == p && m_cnt[i][p] < cmax[i])
            m_cnt[i][p] <= m_cnt[i][p] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i]  = '0;
      dcts_v[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i]  = NP'($urandom_range(1, 31));
      dcts_v[i] = 1'b1;
    end
    tick();
    tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({grant_v[i], xbar_v[i], rts_v[i]} !== '0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got grant=%b xbar=%b rts=%b expected all zero",
                 i, grant_v[i], xbar_v[i], rts_v[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_idle_pick();
    do_reset();
    req_v[0] = 5'b10110; dcts_v[0] = 1'b1;
    tick(); #1;
    n_vec++;
    if (xbar_v[0] !== 5'b00010 || rts_v[0] !== 1'b0 || grant_v[0] !== 5'b0) begin
      n_err++;
      $display("FAIL idle_pick_owner: got xbar=%b rts=%b grant=%b expected 00010/0/00000",
               xbar_v[0], rts_v[0], grant_v[0]);
    end
    tick(); #1;
    n_vec++;
    if (rts_v[0] !== 1'b1 || grant_v[0] !== 5'b00010) begin
      n_err++;
      $display("FAIL idle_pick_grant: got rts=%b grant=%b expected 1/00010", rts_v[0], grant_v[0]);
    end
    tick(); #1;
    n_vec++;
    if (rts_v[0] !== 1'b0 || grant_v[0] !== 5'b0) begin
      n_err++;
      $display("FAIL idle_pick_gap: got rts=%b grant=%b expected 0/00000", rts_v[0], grant_v[0]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_v[0] = 5'b01000; dcts_v[0] = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      req_v[0] = NP'($urandom_range(0, 31));
      #1;
      n_vec++;
      if (grant_v[0] !== 5'b0 || rts_v[0] !== 1'b1 || xbar_v[0] !== 5'b01000) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got grant=%b rts=%b xbar=%b expected 00000/1/01000",
                 c, grant_v[0], rts_v[0], xbar_v[0]);
      end
      tick();
    end
    req_v[0] = 5'b01000; dcts_v[0] = 1'b1;
    #1;
    n_vec++;
    if (grant_v[0] !== 5'b01000) begin
      n_err++;
      $display("FAIL stall_release: got grant=%b expected 01000", grant_v[0]);
    end
    tick(); #1;
    n_vec++;
    if (grant_v[0] !== 5'b0 || rts_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL stall_single_grant: got grant=%b rts=%b expected 00000/0", grant_v[0], rts_v[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_v[0] = 5'b10000; dcts_v[0] = 1'b1;
    tick();
    tick();
    req_v[0] = 5'b00011;
    #1;
    n_vec++;
    if (grant_v[0] !== 5'b10000) begin
      n_err++;
      $display("FAIL wrap_grant4: got grant=%b expected 10000", grant_v[0]);
    end
    tick(); #1;
    n_vec++;
    if (xbar_v[0] !== 5'b00001 || rts_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_owner: got xbar=%b rts=%b expected 00001/0", xbar_v[0], rts_v[0]);
    end
    tick(); #1;
    n_vec++;
    if (grant_v[0] !== 5'b00001) begin
      n_err++;
      $display("FAIL wrap_grant0: got grant=%b expected 00001", grant_v[0]);
    end
  endtask

  task automatic test_fairness();
    int exp_seq[6] = '{0, 0, 1, 1, 0, 0};
    int got = 0;
    int idx;
    do_reset();
    req_v[1] = 5'b00011; dcts_v[1] = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      #1;
      if (grant_v[1] != '0) begin
        idx = -1;
        for (int p = 0; p < NP; p++) if (grant_v[1][p]) idx = p;
        n_vec++;
        if (idx != exp_seq[got]) begin
          n_err++;
          $display("FAIL fairness_seq[%0d]: got port %0d expected port %0d", got, idx, exp_seq[got]);
        end
        got++;
      end
      tick();
    end
    n_vec++;
    if (got != 6) begin
      n_err++;
      $display("FAIL fairness_timeout: got %0d grants expected 6", got);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_v[0] = 5'b00100; dcts_v[0] = 1'b1;
    repeat (4) tick();
    #1;
    n_vec++;
    if (rts_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pre: got rts=%b expected 1", rts_v[0]);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (grant_v[0] !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_nogrant: got grant=%b expected 00000", grant_v[0]);
    end
    tick(); #1;
    n_vec++;
    if (xbar_v[0] !== 5'b0 || rts_v[0] !== 1'b0 || grant_v[0] !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_state: got xbar=%b rts=%b grant=%b expected zeros",
               xbar_v[0], rts_v[0], grant_v[0]);
    end
`ifdef ARB_GRANT_CNT_EN
    n_vec++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      n_err++;
      $display("FAIL reset_mid_cnt: got a=%h b=%h expected 0", cnt_a, cnt_b);
    end
`endif
    rst = 1'b0;
  endtask

`ifdef ARB_GRANT_CNT_EN
  task automatic test_counter_sat();
    int got = 0;
    do_reset();
    req_v[1] = 5'b00100; dcts_v[1] = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      #1;
      if (grant_v[1] != '0) got++;
      if (got == 5) req_v[1] = '0;
      tick();
    end
    #1;
    n_vec++;
    if (got != 5) begin
      n_err++;
      $display("FAIL cnt_sat_timeout: got %0d grants expected 5", got);
    end
    n_vec++;
    if (cnt_b !== 10'b00_00_11_00_00) begin
      n_err++;
      $display("FAIL cnt_sat_value: got %b expected 0000110000", cnt_b);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      tick();
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        req_v[i]  = ($urandom_range(0, 3) == 0) ? NP'(1 << $urandom_range(0, NP - 1))
                                                : NP'($urandom_range(0, 31));
        dcts_v[i] = ($urandom_range(0, 9) < 7);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (grant_v[i] !== exp_grant(i) || xbar_v[i] !== exp_xbar(i) || rts_v[i] !== m_rts[i]) begin
          n_err++;
          $display("FAIL random[%0d] dut%0d: got grant=%b xbar=%b rts=%b expected %b/%b/%b", n, i,
                   grant_v[i], xbar_v[i], rts_v[i], exp_grant(i), exp_xbar(i), m_rts[i]);
        end
      end
`ifdef ARB_GRANT_CNT_EN
      for (int p = 0; p < NP; p++) begin
        n_vec++;
        if (cnt_a[p*8 +: 8] !== 8'(m_cnt[0][p]) || cnt_b[p*2 +: 2] !== 2'(m_cnt[1][p])) begin
          n_err++;
          $display("FAIL random_cnt[%0d] port %0d: got %0d/%0d expected %0d/%0d", n, p,
                   cnt_a[p*8 +: 8], cnt_b[p*2 +: 2], m_cnt[0][p], m_cnt[1][p]);
        end
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i]  = '0;
      dcts_v[i] = 1'b0;
    end
    test_reset();
    test_idle_pick();
    test_stall();
    test_wrap();
    test_fairness();
    test_reset_mid();
`ifdef ARB_GRANT_CNT_EN
    test_counter_sat();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
